alu_6502: RTL and testbench

8-bit arithmetic/logic unit for the 6502-compatible CPU core. It performs add with carry, subtract with borrow, compare, AND/OR/EOR, and logical shift right. It also produces the C, V, Z and N status bits used to update the processor status register. Results and flags are registered: one clock of latency, synchronous active-high reset.

---
 rtl/alu_6502.sv | 109 ++++++++++
 tb/tb_alu_6502.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu_6502.sv
`default_nettype none
// ============================================================================
// Module   : alu_6502
// Brief    : 8-bit registered ALU (ADC/SBC/CMP/AND/ORA/EOR/LSR) with C,V,Z,N
// Revision : 1.0 - initial release
// ============================================================================
module alu_6502 (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] alu_a,
    input  logic [7:0] alu_b,
    input  logic [4:0] mode,
    input  logic       carry_in,
    output logic [7:0] alu_out,
    output logic       carry_out,
    output logic       overflow,
    output logic       zero,
    output logic       sign
);

    localparam logic [4:0] c_mode_add = 5'd0;
    localparam logic [4:0] c_mode_and = 5'd1;
    localparam logic [4:0] c_mode_or  = 5'd2;
    localparam logic [4:0] c_mode_eor = 5'd3;
    localparam logic [4:0] c_mode_sr  = 5'd4;
    localparam logic [4:0] c_mode_sub = 5'd5;
    localparam logic [4:0] c_mode_cmp = 5'd6;

    logic [8:0] w_sum_add;
    logic [8:0] w_sum_sub;
    logic [8:0] w_sum_cmp;
    logic [7:0] w_res;
    logic       w_carry;
    logic       w_ovf;

    logic [7:0] r_out;
    logic       r_carry;
    logic       r_ovf;
    logic       r_zero;
    logic       r_sign;

    // Subtraction is addition of the ones' complement; CMP always behaves as if C=1.
    assign w_sum_add = {1'b0, alu_a} + {1'b0, alu_b}  + {8'd0, carry_in};
    assign w_sum_sub = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'd0, carry_in};
    assign w_sum_cmp = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;

    always_comb begin
        w_res   = w_sum_add[7:0];
        w_carry = w_sum_add[8];
        w_ovf   = (alu_a[7] == alu_b[7]) && (w_sum_add[7] != alu_a[7]);
        case (mode)
            c_mode_and: begin
                w_res   = alu_a & alu_b;
                w_carry = carry_in;
                w_ovf   = 1'b0;
            end
            c_mode_or: begin
                w_res   = alu_a | alu_b;
                w_carry = carry_in;
                w_ovf   = 1'b0;
            end
            c_mode_eor: begin
                w_res   = alu_a ^ alu_b;
                w_carry = carry_in;
                w_ovf   = 1'b0;
            end
            c_mode_sr: begin
                w_res   = {1'b0, alu_a[7:1]};
                w_carry = alu_a[0];
                w_ovf   = 1'b0;
            end
            c_mode_sub: begin
                w_res   = w_sum_sub[7:0];
                w_carry = w_sum_sub[8];
                w_ovf   = (alu_a[7] != alu_b[7]) && (w_sum_sub[7] != alu_a[7]);
            end
            c_mode_cmp: begin
                w_res   = w_sum_cmp[7:0];
                w_carry = w_sum_cmp[8];
                w_ovf   = 1'b0;
            end
            default: ; // ADD and all unused encodings
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out   <= 8'h00;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
            r_sign  <= 1'b0;
        end else begin
            r_out   <= w_res;
            r_carry <= w_carry;
            r_ovf   <= w_ovf;
            r_zero  <= (w_res == 8'h00);
            r_sign  <= w_res[7];
        end
    end

    assign alu_out   = r_out;
    assign carry_out = r_carry;
    assign overflow  = r_ovf;
    assign zero      = r_zero;
    assign sign      = r_sign;

endmodule
`default_nettype wire

// File: tb/tb_alu_6502.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_6502
// Brief    : Self-checking bench for alu_6502 (directed table + random vs model)
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_6502;

    logic       clk;
    logic       reset;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [4:0] mode;
    logic       carry_in;
    logic [7:0] alu_out;
    logic       carry_out;
    logic       overflow;
    logic       zero;
    logic       sign;

    int err_cnt;
    int chk_cnt;

    alu_6502 u_dut (
        .clk       (clk),
        .reset     (reset),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .mode      (mode),
        .carry_in  (carry_in),
        .alu_out   (alu_out),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .sign      (sign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view {C, V, Z, N, result}
    function automatic logic [11:0] observed();
        return {carry_out, overflow, zero, sign, alu_out};
    endfunction

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got CVZN=%b r=%h, expected CVZN=%b r=%h",
                     tag, got[11:8], got[7:0], exp[11:8], exp[7:0]);
        end
    endtask

    // Reference model in integer arithmetic; V from the true signed result range.
    function automatic logic [11:0] model(int a, int b, int m, int cin);
        int sa, sb, s, r, c, v;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        c = 0;
        v = 0;
        case (m)
            1: begin r = a & b; c = cin; end
            2: begin r = a | b; c = cin; end
            3: begin r = a ^ b; c = cin; end
            4: begin r = a / 2; c = a % 2; end
            5: begin
                s = a - b - (1 - cin);
                r = s & 255;
                c = (s >= 0) ? 1 : 0;
                s = sa - sb - (1 - cin);
                v = (s < -128 || s > 127) ? 1 : 0;
            end
            6: begin
                r = (a - b) & 255;
                c = (a >= b) ? 1 : 0;
            end
            default: begin
                s = a + b + cin;
                r = s & 255;
                c = (s > 255) ? 1 : 0;
                s = sa + sb + cin;
                v = (s < -128 || s > 127) ? 1 : 0;
            end
        endcase
        return {c[0], v[0], (r == 0), (r > 127), r[7:0]};
    endfunction

    task automatic drive(input logic [7:0] a, input logic [7:0] b,
                         input logic [4:0] m, input logic cin);
        alu_a    = a;
        alu_b    = b;
        mode     = m;
        carry_in = cin;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       tag;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [4:0]  m;
        logic        cin;
        logic [11:0] exp;   // {C,V,Z,N,r}
    } vec_t;

    vec_t dir_tbl[$];

    initial begin
        err_cnt  = 0;
        chk_cnt  = 0;
        reset    = 1'b1;
        alu_a    = 8'hFF;
        alu_b    = 8'h01;
        mode     = 5'd0;
        carry_in = 1'b1;

        // Reset held two edges with inputs that would otherwise give Z=1, C=1
        @(posedge clk); #1;
        check("reset_edge1", observed(), 12'h000);
        @(posedge clk); #1;
        check("reset_edge2", observed(), 12'h000);
        reset = 1'b0;

        dir_tbl = '{
            '{"add_01_02",   8'h01, 8'h02, 5'd0,  1'b0, {4'b0000, 8'h03}},
            '{"add_50_50",   8'h50, 8'h50, 5'd0,  1'b0, {4'b0101, 8'hA0}},
            '{"add_ff_01",   8'hFF, 8'h01, 5'd0,  1'b0, {4'b1010, 8'h00}},
            '{"add_7f_c",    8'h7F, 8'h00, 5'd0,  1'b1, {4'b0101, 8'h80}},
            '{"sub_50_b0",   8'h50, 8'hB0, 5'd5,  1'b1, {4'b0101, 8'hA0}},
            '{"sub_05_03",   8'h05, 8'h03, 5'd5,  1'b0, {4'b1000, 8'h01}},
            '{"cmp_eq",      8'h40, 8'h40, 5'd6,  1'b0, {4'b1010, 8'h00}},
            '{"cmp_lt",      8'h10, 8'h20, 5'd6,  1'b1, {4'b0001, 8'hF0}},
            '{"and_zero",    8'hF0, 8'h0F, 5'd1,  1'b1, {4'b1010, 8'h00}},
            '{"or_ff",       8'hF0, 8'h0F, 5'd2,  1'b0, {4'b0001, 8'hFF}},
            '{"eor_55",      8'hAA, 8'hFF, 5'd3,  1'b1, {4'b1000, 8'h55}},
            '{"sr_81",       8'h81, 8'h33, 5'd4,  1'b0, {4'b1000, 8'h40}},
            '{"sr_01",       8'h01, 8'hFF, 5'd4,  1'b0, {4'b1010, 8'h00}},
            '{"sr_fe",       8'hFE, 8'h00, 5'd4,  1'b1, {4'b0000, 8'h7F}},
            '{"mode7_add",   8'h80, 8'h80, 5'd7,  1'b0, {4'b1110, 8'h00}},
            '{"mode31_add",  8'h10, 8'h20, 5'd31, 1'b1, {4'b0000, 8'h31}}
        };

        foreach (dir_tbl[i]) begin
            drive(dir_tbl[i].a, dir_tbl[i].b, dir_tbl[i].m, dir_tbl[i].cin);
            check(dir_tbl[i].tag, observed(), dir_tbl[i].exp);
        end

        // Holding the last inputs must hold the outputs
        @(posedge clk); #1;
        check("hold", observed(), {4'b0000, 8'h31});

        // Back-to-back random vectors, a mid-stream reset, then more vectors
        for (int i = 0; i < 30; i++) begin
            logic [7:0] ra, rb;
            logic [4:0] rm;
            logic       rc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rm = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
            rc = 1'($urandom);
            if (i == 20) begin
                reset = 1'b1;
                drive(8'hFF, 8'h01, 5'd0, 1'b1);
                check("reset_midstream", observed(), 12'h000);
                reset = 1'b0;
            end
            drive(ra, rb, rm, rc);
            check($sformatf("rand%0d_m%0d_%h_%h_c%0d", i, rm, ra, rb, rc),
                  observed(), model(int'(ra), int'(rb), int'(rm), int'(rc)));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
